// File: rtl/l2_bus_pkg.sv
// Shared-bus snoop protocol definitions: opcodes, MESI and snoop result
// encodings and the snoop responder FSM states.
package l2_bus_pkg;

  localparam logic [7:0] OP_READ  = 8'h01;
  localparam logic [7:0] OP_WRITE = 8'h02;
  localparam logic [7:0] OP_INV   = 8'h03;
  localparam logic [7:0] OP_RWIM  = 8'h04;

  typedef enum logic [1:0] {
    MESI_I = 2'd0,
    MESI_S = 2'd1,
    MESI_E = 2'd2,
    MESI_M = 2'd3
  } mesi_e;

  typedef enum logic [1:0] {
    SNP_NOHIT = 2'd0,
    SNP_HIT   = 2'd1,
    SNP_HITM  = 2'd2
  } snp_result_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_RESPOND,
    ST_WRITEBACK,
    ST_UPDATE
  } snp_state_e;

  function automatic logic op_known(input logic [7:0] op);
    return (op == OP_READ) || (op == OP_WRITE) ||
           (op == OP_INV) || (op == OP_RWIM);
  endfunction

endpackage

// File: rtl/snoop_decision.sv
// Combinational snoop decision: (op, hit, MESI state) to
// (result, new state, state change, protocol error).
module snoop_decision
  import l2_bus_pkg::*;
(
  input  logic [7:0] op,
  input  logic       hit,
  input  logic [1:0] state,
  output logic [1:0] result,
  output logic [1:0] new_state,
  output logic       state_change,
  output logic       error
);

  logic valid;
  logic dirty;

  assign valid = hit && (state != MESI_I);
  assign dirty = valid && (state == MESI_M);

  always_comb begin
    result       = SNP_NOHIT;
    new_state    = state;
    state_change = 1'b0;
    error        = 1'b0;
    case (op)
      OP_READ: begin
        if (valid) begin
          result = dirty ? SNP_HITM : SNP_HIT;
          if (state != MESI_S) begin
            new_state    = MESI_S;
            state_change = 1'b1;
          end
        end
      end
      OP_RWIM: begin
        if (valid) begin
          result       = dirty ? SNP_HITM : SNP_HIT;
          new_state    = MESI_I;
          state_change = 1'b1;
        end
      end
      OP_INV: begin
        // Another agent invalidating a line we own exclusively is illegal
        if (valid) begin
          new_state    = MESI_I;
          state_change = 1'b1;
          error        = (state != MESI_S);
        end
      end
      OP_WRITE: error = valid;
      default: ;
    endcase
  end

endmodule

// File: rtl/snoop_responder.sv
// Shared-bus snoop responder: tag lookup, snoop result, writeback, MESI update.
// Define SNOOP_STATS_EN to add saturating hit/hitm/nohit counters.
module snoop_responder
  import l2_bus_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int INDEX_W  = 14,
  parameter int OFFSET_W = 6,
  parameter int WAY_W    = 3,
  localparam int TAG_W   = ADDR_W - INDEX_W - OFFSET_W
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               bus_op_valid,
  input  logic [7:0]         bus_op,
  input  logic [ADDR_W-1:0]  bus_addr,
  input  logic               bus_own,
  output logic               op_ready,
  output logic               lk_req,
  output logic [INDEX_W-1:0] lk_index,
  output logic [TAG_W-1:0]   lk_tag,
  input  logic               lk_ack,
  input  logic               lk_hit,
  input  logic [WAY_W-1:0]   lk_way,
  input  logic [1:0]         lk_state,
  output logic               snoop_valid,
  output logic [1:0]         snoop_result,
  output logic               wb_req,
  output logic [INDEX_W-1:0] wb_index,
  output logic [WAY_W-1:0]   wb_way,
  input  logic               wb_ack,
  output logic               upd_valid,
  output logic [INDEX_W-1:0] upd_index,
  output logic [WAY_W-1:0]   upd_way,
  output logic [1:0]         upd_state,
  output logic               protocol_error
`ifdef SNOOP_STATS_EN
  ,
  output logic [31:0]        stat_hit,
  output logic [31:0]        stat_hitm,
  output logic [31:0]        stat_nohit
`endif
);

  snp_state_e         state_q, state_d;
  logic [INDEX_W-1:0] index_q, index_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [7:0]         op_q, op_d;
  logic               hit_q, hit_d;
  logic [WAY_W-1:0]   way_q, way_d;
  logic [1:0]         mesi_q, mesi_d;

  logic [1:0] dec_result;
  logic [1:0] dec_state;
  logic       dec_change;
  logic       dec_error;
  logic       accept;
  logic       unused_offset;

  assign unused_offset = ^bus_addr[OFFSET_W-1:0];

  snoop_decision u_decision (
    .op           (op_q),
    .hit          (hit_q),
    .state        (mesi_q),
    .result       (dec_result),
    .new_state    (dec_state),
    .state_change (dec_change),
    .error        (dec_error)
  );

  assign accept = bus_op_valid && !bus_own && op_ready &&
                  op_known(bus_op);

  always_comb begin
    state_d = state_q;
    index_d = index_q;
    tag_d   = tag_q;
    op_d    = op_q;
    hit_d   = hit_q;
    way_d   = way_q;
    mesi_d  = mesi_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          index_d = bus_addr[OFFSET_W +: INDEX_W];
          tag_d   = bus_addr[ADDR_W-1 -: TAG_W];
          op_d    = bus_op;
          state_d = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        if (lk_ack) begin
          hit_d   = lk_hit;
          way_d   = lk_way;
          mesi_d  = lk_state;
          state_d = ST_RESPOND;
        end
      end
      ST_RESPOND: begin
        // Dirty data must reach memory before the line is downgraded
        if (dec_result == SNP_HITM) state_d = ST_WRITEBACK;
        else if (dec_change)        state_d = ST_UPDATE;
        else                        state_d = ST_IDLE;
      end
      ST_WRITEBACK: if (wb_ack) state_d = ST_UPDATE;
      ST_UPDATE:    state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      index_q <= '0;
      tag_q   <= '0;
      op_q    <= '0;
      hit_q   <= 1'b0;
      way_q   <= '0;
      mesi_q  <= '0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      tag_q   <= tag_d;
      op_q    <= op_d;
      hit_q   <= hit_d;
      way_q   <= way_d;
      mesi_q  <= mesi_d;
    end
  end

  assign op_ready       = (state_q == ST_IDLE);
  assign lk_req         = (state_q == ST_LOOKUP);
  assign lk_index       = index_q;
  assign lk_tag         = tag_q;
  assign snoop_valid    = (state_q == ST_RESPOND);
  assign snoop_result   = snoop_valid ? dec_result : SNP_NOHIT;
  assign protocol_error = snoop_valid && dec_error;
  assign wb_req         = (state_q == ST_WRITEBACK);
  assign wb_index       = index_q;
  assign wb_way         = way_q;
  assign upd_valid      = (state_q == ST_UPDATE);
  assign upd_index      = index_q;
  assign upd_way        = way_q;
  assign upd_state      = dec_state;

`ifdef SNOOP_STATS_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] hitm_cnt_q, hitm_cnt_d;
  logic [31:0] nohit_cnt_q, nohit_cnt_d;

  always_comb begin
    hit_cnt_d   = hit_cnt_q;
    hitm_cnt_d  = hitm_cnt_q;
    nohit_cnt_d = nohit_cnt_q;
    if (snoop_valid) begin
      case (snoop_result)
        SNP_HIT:  if (~&hit_cnt_q)   hit_cnt_d   = hit_cnt_q + 32'd1;
        SNP_HITM: if (~&hitm_cnt_q)  hitm_cnt_d  = hitm_cnt_q + 32'd1;
        default:  if (~&nohit_cnt_q) nohit_cnt_d = nohit_cnt_q + 32'd1;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hit_cnt_q   <= '0;
      hitm_cnt_q  <= '0;
      nohit_cnt_q <= '0;
    end else begin
      hit_cnt_q   <= hit_cnt_d;
      hitm_cnt_q  <= hitm_cnt_d;
      nohit_cnt_q <= nohit_cnt_d;
    end
  end

  assign stat_hit   = hit_cnt_q;
  assign stat_hitm  = hitm_cnt_q;
  assign stat_nohit = nohit_cnt_q;
`endif

endmodule

// File: tb/tb_snoop_responder.sv
// Randomized self-checking bench for snoop_responder against a
// transaction-level MESI snoop model.
module tb_snoop_responder;
  import l2_bus_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        bus_op_valid;
  logic [7:0]  bus_op;
  logic [31:0] bus_addr;
  logic        bus_own;
  logic        op_ready;
  logic        lk_req;
  logic [13:0] lk_index;
  logic [11:0] lk_tag;
  logic        lk_ack;
  logic        lk_hit;
  logic [2:0]  lk_way;
  logic [1:0]  lk_state;
  logic        snoop_valid;
  logic [1:0]  snoop_result;
  logic        wb_req;
  logic [13:0] wb_index;
  logic [2:0]  wb_way;
  logic        wb_ack;
  logic        upd_valid;
  logic [13:0] upd_index;
  logic [2:0]  upd_way;
  logic [1:0]  upd_state;
  logic        protocol_error;
`ifdef SNOOP_STATS_EN
  logic [31:0] stat_hit, stat_hitm, stat_nohit;
  int unsigned m_hit = 0, m_hitm = 0, m_nohit = 0;
`endif

  int checks = 0;
  int errors = 0;

  // Per-cycle expectations, written by the driver after each edge
  bit          chk_en = 0;
  bit          e_ready, e_lk, e_snoop, e_wb, e_upd, e_err;
  logic [1:0]  e_result, e_upd_state;
  logic [13:0] e_index;
  logic [11:0] e_tag;
  logic [2:0]  e_way;

  snoop_responder dut (
    .clock(clock), .reset(reset),
    .bus_op_valid(bus_op_valid), .bus_op(bus_op),
    .bus_addr(bus_addr), .bus_own(bus_own),
    .op_ready(op_ready), .lk_req(lk_req),
    .lk_index(lk_index), .lk_tag(lk_tag),
    .lk_ack(lk_ack), .lk_hit(lk_hit),
    .lk_way(lk_way), .lk_state(lk_state),
    .snoop_valid(snoop_valid), .snoop_result(snoop_result),
    .wb_req(wb_req), .wb_index(wb_index),
    .wb_way(wb_way), .wb_ack(wb_ack),
    .upd_valid(upd_valid), .upd_index(upd_index),
    .upd_way(upd_way), .upd_state(upd_state),
    .protocol_error(protocol_error)
`ifdef SNOOP_STATS_EN
    , .stat_hit(stat_hit), .stat_hitm(stat_hitm),
    .stat_nohit(stat_nohit)
`endif
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, got, exp, $time);
    end
  endtask

  // Snoop rules from the protocol table, at transaction level
  function automatic void model(input logic [7:0] op, input bit hit,
      input logic [1:0] st, output logic [1:0] res,
      output bit chg, output logic [1:0] ns, output bit err);
    bit owned = hit && (st != 2'd0);
    bit dirty = owned && (st == 2'd3);
    res = 2'd0; chg = 0; ns = st; err = 0;
    if (op == OP_READ || op == OP_RWIM) begin
      if (owned) res = dirty ? 2'd2 : 2'd1;
      if (op == OP_RWIM) begin chg = owned; ns = 2'd0; end
      else if (owned && st != 2'd1) begin chg = 1; ns = 2'd1; end
    end else if (op == OP_INV) begin
      chg = owned; ns = 2'd0; err = owned && (st != 2'd1);
    end else if (op == OP_WRITE) begin
      err = owned;
    end
    if (!chg) ns = st;
  endfunction

  always @(negedge clock) begin
    if (chk_en) begin
      chk("op_ready", op_ready, e_ready);
      chk("lk_req", lk_req, e_lk);
      chk("snoop_valid", snoop_valid, e_snoop);
      chk("snoop_result", snoop_result, e_result);
      chk("protocol_error", protocol_error, e_err);
      chk("wb_req", wb_req, e_wb);
      chk("upd_valid", upd_valid, e_upd);
      if (e_lk) begin
        chk("lk_index", lk_index, e_index);
        chk("lk_tag", lk_tag, e_tag);
      end
      if (e_wb) begin
        chk("wb_index", wb_index, e_index);
        chk("wb_way", wb_way, e_way);
      end
      if (e_upd) begin
        chk("upd_index", upd_index, e_index);
        chk("upd_way", upd_way, e_way);
        chk("upd_state", upd_state, e_upd_state);
      end
`ifdef SNOOP_STATS_EN
      chk("stat_hit", stat_hit, m_hit);
      chk("stat_hitm", stat_hitm, m_hitm);
      chk("stat_nohit", stat_nohit, m_nohit);
      if (reset) begin
        m_hit = 0; m_hitm = 0; m_nohit = 0;
      end else if (e_snoop) begin
        if (e_result == 2'd1) m_hit++;
        else if (e_result == 2'd2) m_hitm++;
        else m_nohit++;
      end
`endif
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic exp_idle();
    e_ready = 1; e_lk = 0; e_snoop = 0; e_wb = 0;
    e_upd = 0; e_err = 0; e_result = 2'd0;
  endtask

  task automatic run_txn(input logic [7:0] op, input logic [31:0] addr,
      input bit own, input bit hit, input logic [1:0] st,
      input logic [2:0] way, input int lkd, input int wbd,
      input bit abort_wb);
    logic [1:0] res, ns;
    bit chg, err;
    exp_idle();
    bus_op_valid = 1; bus_op = op; bus_addr = addr; bus_own = own;
    step();
    bus_op_valid = 0; bus_op = 8'($urandom); bus_addr = $urandom;
    exp_idle();
    if (own || !(op inside {OP_READ, OP_WRITE, OP_INV, OP_RWIM})) begin
      step();
      return;
    end
    model(op, hit, st, res, chg, ns, err);
    e_index = addr[19:6]; e_tag = addr[31:20]; e_way = way;
    e_ready = 0;
    for (int k = 0; k <= lkd; k++) begin
      e_lk = 1;
      lk_ack = (k == lkd);
      lk_hit = (k == lkd) ? hit : 1'($urandom);
      lk_way = (k == lkd) ? way : 3'($urandom);
      lk_state = (k == lkd) ? st : 2'($urandom);
      step();
    end
    lk_ack = 0; lk_hit = 1'($urandom);
    lk_way = 3'($urandom); lk_state = 2'($urandom);
    e_lk = 0; e_snoop = 1; e_result = res; e_err = err;
    step();
    e_snoop = 0; e_result = 2'd0; e_err = 0;
    if (res == 2'd2) begin
      for (int k = 0; k <= wbd; k++) begin
        e_wb = 1;
        wb_ack = (k == wbd) && !abort_wb;
        if (abort_wb && k == wbd) reset = 1;
        step();
      end
      wb_ack = 0; e_wb = 0;
      if (abort_wb) begin
        reset = 0;
        exp_idle();
        step();
        return;
      end
    end
    if (chg) begin
      e_upd = 1; e_upd_state = ns;
      step();
      e_upd = 0;
    end
    exp_idle();
  endtask

  initial begin
    logic [1:0] r, n;
    bit c, er;
    reset = 1; bus_op_valid = 0; bus_op = 0; bus_addr = 0;
    bus_own = 0; lk_ack = 0; lk_hit = 0; lk_way = 0;
    lk_state = 0; wb_ack = 0;
    exp_idle();
    repeat (2) step();
    chk_en = 1;
    step();
    reset = 0;

    model(OP_READ, 1, 2'd3, r, c, n, er);
    chk("pin read_m res", r, 2'd2);
    chk("pin read_m ns", n, 2'd1);
    model(OP_INV, 1, 2'd2, r, c, n, er);
    chk("pin inv_e err", er, 1'b1);
    chk("pin inv_e ns", n, 2'd0);
    model(OP_WRITE, 1, 2'd1, r, c, n, er);
    chk("pin write_s chg", c, 1'b0);
    model(OP_RWIM, 0, 2'd3, r, c, n, er);
    chk("pin rwim_miss res", r, 2'd0);

    run_txn(OP_READ, 32'hABCD_1240, 0, 1, 2'd3, 3'd5, 0, 2, 0);
    run_txn(OP_RWIM, 32'h1234_5680, 0, 1, 2'd2, 3'd2, 1, 0, 0);
    run_txn(OP_READ, 32'hFFFF_FFC0, 0, 0, 2'd1, 3'd0, 0, 0, 0);
    run_txn(OP_INV, 32'h0000_0040, 0, 1, 2'd3, 3'd7, 2, 0, 0);
    run_txn(OP_WRITE, 32'h8000_1000, 0, 1, 2'd1, 3'd1, 0, 0, 0);
    run_txn(OP_READ, 32'h5555_5500, 1, 1, 2'd3, 3'd1, 0, 0, 0);
    run_txn(8'h07, 32'h5555_5500, 0, 1, 2'd3, 3'd1, 0, 0, 0);
    run_txn(OP_READ, 32'h2468_ACE0, 0, 1, 2'd3, 3'd4, 0, 2, 1);
    step();

    for (int i = 0; i < 400; i++) begin
      logic [7:0] op;
      case ($urandom_range(0, 9))
        0, 1:    op = OP_READ;
        2, 3:    op = OP_RWIM;
        4:       op = OP_INV;
        5:       op = OP_WRITE;
        6:       op = 8'($urandom);
        default: op = 8'($urandom_range(1, 4));
      endcase
      run_txn(op, $urandom, ($urandom_range(0, 7) == 0),
              ($urandom_range(0, 3) != 0), 2'($urandom),
              3'($urandom), $urandom_range(0, 3),
              $urandom_range(0, 3), ($urandom_range(0, 19) == 0));
    end
    step();
    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
